// File: rtl/lm_multi_logger.sv
// Multi-source event logger: config, error and UART data events feed one-entry pending
// slots, a round-robin arbiter moves them into a record FIFO drained by a ready/valid port.
module lm_multi_logger #(
    parameter int unsigned NUM_ERR_CH = 2,
    parameter int unsigned ERR_W      = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CFG_W      = 4,
    parameter int unsigned PAY_W      = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         UART_data_debug_switch,
    input  logic [DATA_W-1:0]            UART_data,
    input  logic                         UART_data_valid,
    input  logic [NUM_ERR_CH*ERR_W-1:0]  err,
    input  logic [NUM_ERR_CH-1:0]        err_valid,
    input  logic [CFG_W-1:0]             config_notification,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_tag,
    output logic [2:0]                   out_chan,
    output logic [PAY_W-1:0]             out_payload,
    output logic [7:0]                   drop_count
);

    localparam int unsigned NSRC = NUM_ERR_CH + 2;
    localparam int unsigned SW   = $clog2(NSRC);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned RW   = 2 + 3 + PAY_W;

    logic [CFG_W-1:0] cfg_q;
    logic [NSRC-1:0]  pend_q, pend_d, ev, gnt_vec;
    logic [PAY_W-1:0] pay_q  [NSRC];
    logic [PAY_W-1:0] pay_d  [NSRC];
    logic [PAY_W-1:0] ev_pay [NSRC];
    logic [SW-1:0]    rr_q, rr_d, gnt_idx;
    logic             gnt_any;
    logic [1:0]       push_tag;
    logic [2:0]       push_chan;
    logic [RW-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       drop_q, drop_d, ndrop;
    logic [8:0]       drop_sum;
    logic             pop, can_push;

    // Source order: 0 = config, 1..NUM_ERR_CH = error channels, last = UART data
    always_comb begin
        ev = '0;
        for (int s = 0; s < NSRC; s++) ev_pay[s] = '0;
        ev[0]     = (config_notification != cfg_q);
        ev_pay[0] = PAY_W'(config_notification);
        for (int k = 0; k < NUM_ERR_CH; k++) begin
            ev[k+1]     = err_valid[k];
            ev_pay[k+1] = PAY_W'(err[k*ERR_W +: ERR_W]);
        end
        ev[NSRC-1]     = UART_data_valid & UART_data_debug_switch;
        ev_pay[NSRC-1] = PAY_W'(UART_data);
    end

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign can_push  = (cnt_q < CW'(FIFO_DEPTH)) | pop;

    // Round-robin search starting at rr_q; first pending slot wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (can_push && !gnt_any && pend_q[(int'(rr_q) + k) % NSRC]) begin
                gnt_any = 1'b1;
                gnt_idx = SW'((int'(rr_q) + k) % NSRC);
            end
        end
        rr_d = rr_q;
        if (gnt_any) rr_d = (gnt_idx == SW'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
        gnt_vec = '0;
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end

    always_comb begin
        push_tag  = 2'b01;
        push_chan = 3'(gnt_idx - 1'b1);
        if (gnt_idx == '0) begin
            push_tag  = 2'b10;
            push_chan = 3'd0;
        end else if (gnt_idx == SW'(NSRC - 1)) begin
            push_tag  = 2'b00;
            push_chan = 3'd0;
        end
    end

    // A granted slot may reload in the same cycle; a busy, ungranted slot drops the event
    always_comb begin
        ndrop = '0;
        for (int s = 0; s < NSRC; s++) begin
            pend_d[s] = pend_q[s];
            pay_d[s]  = pay_q[s];
            if (ev[s] && (!pend_q[s] || gnt_vec[s])) begin
                pend_d[s] = 1'b1;
                pay_d[s]  = ev_pay[s];
            end else if (ev[s]) begin
                ndrop = ndrop + 8'd1;
            end else if (gnt_vec[s]) begin
                pend_d[s] = 1'b0;
            end
        end
        drop_sum = {1'b0, drop_q} + {1'b0, ndrop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        cnt_d    = cnt_q + CW'(gnt_any) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q  <= '0;
            pend_q <= '0;
            rr_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
            for (int s = 0; s < NSRC; s++) pay_q[s] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cfg_q  <= config_notification;
            pend_q <= pend_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            for (int s = 0; s < NSRC; s++) pay_q[s] <= pay_d[s];
            if (gnt_any) begin
                mem_q[wr_q] <= {push_tag, push_chan, pay_q[gnt_idx]};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
        end
    end

    assign {out_tag, out_chan, out_payload} = mem_q[rd_q];
    assign drop_count = drop_q;

endmodule
